// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, a - b - bin.
// One full-subtractor cell walks the operands LSB first and keeps the borrow
// in a register. The result is assembled MSB-down in a shift register.
// The output flags are loaded only on the edge that completes an operation.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    // Full-subtractor difference bit.
    function automatic logic fs_diff(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    // Full-subtractor borrow: borrow when x < y + bi for single bits.
    function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic             brw_q, brw_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             d_s;
    logic             brw_nxt_s;
    logic [WIDTH-1:0] res_s;

    assign d_s       = fs_diff(ra_q[0], rb_q[0], brw_q);
    assign brw_nxt_s = fs_borrow(ra_q[0], rb_q[0], brw_q);
    assign res_s     = {d_s, rd_q[WIDTH-1:1]};

    // Next-state, datapath and result-register computation.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rd_d    = rd_q;
        brw_d   = brw_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    brw_d   = bin;
                    sa_d    = a[WIDTH-1];
                    sb_d    = b[WIDTH-1];
                    cnt_d   = CNT_ZERO;
                    rd_d    = {WIDTH{1'b0}};
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                brw_d = brw_nxt_s;
                rd_d  = res_s;
                ra_d  = {1'b0, ra_q[WIDTH-1:1]};
                rb_d  = {1'b0, rb_q[WIDTH-1:1]};
                if (cnt_q == CNT_LAST) begin
                    // Hold the counter on the last bit so it never wraps.
                    cnt_d   = cnt_q;
                    state_d = ST_DONE;
                    diff_d  = res_s;
                    bout_d  = brw_nxt_s;
                    zero_d  = (res_s == {WIDTH{1'b0}});
                    ovf_d   = (sa_q != sb_q) && (d_s != sa_q);
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ra_q    <= {WIDTH{1'b0}};
            rb_q    <= {WIDTH{1'b0}};
            rd_q    <= {WIDTH{1'b0}};
            brw_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            cnt_q   <= CNT_ZERO;
            diff_q  <= {WIDTH{1'b0}};
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rd_q    <= rd_d;
            brw_q   <= brw_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: a 4-bit and an 8-bit instance checked every
// cycle against an arithmetic reference model, plus directed literal cases.
module tb_serial_subtractor;

    typedef struct packed {
        logic        bout;
        logic        ovf;
        logic        zero;
        logic [31:0] diff;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st [2];
    logic [31:0] ai [2];
    logic [31:0] bi [2];
    logic        bn [2];

    logic [3:0] d4;
    logic       bo4, ov4, z4, bu4, dn4;
    logic [7:0] d8;
    logic       bo8, ov8, z8, bu8, dn8;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .a(ai[0][3:0]), .b(bi[0][3:0]),
        .bin(bn[0]), .diff(d4), .bout(bo4), .ovf(ov4), .zero(z4), .busy(bu4), .done(dn4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .a(ai[1][7:0]), .b(bi[1][7:0]),
        .bin(bn[1]), .diff(d8), .bout(bo8), .ovf(ov8), .zero(z8), .busy(bu8), .done(dn8)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int wid(input int u);
        return (u == 0) ? 4 : 8;
    endfunction

    // Reference result: plain integer subtraction, sign rule on operand/result MSBs.
    function automatic res_t ref_res(input int w, input logic [31:0] a, input logic [31:0] b,
                                     input logic bi_in);
        longint mask;
        longint t;
        logic   a_neg;
        logic   b_neg;
        res_t   r;
        mask   = (longint'(1) << w) - longint'(1);
        t      = longint'(a & 32'(mask)) - longint'(b & 32'(mask)) - longint'(bi_in);
        r.diff = 32'(t & mask);
        r.bout = (t < 0);
        r.zero = (r.diff == 32'd0);
        a_neg  = a[w-1];
        b_neg  = b[w-1];
        r.ovf  = (a_neg != b_neg) && (r.diff[w-1] != a_neg);
        return r;
    endfunction

    // Model: phase 0 idle, 1..w computing, w+1 result strobe.
    int          m_phase [2];
    logic [31:0] m_a [2];
    logic [31:0] m_b [2];
    logic        m_bin [2];
    res_t        e_res [2];
    int          acc_cnt [2];
    int          done_cnt [2];

    // Cycle-level reference model of both instances.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int u = 0; u < 2; u++) begin
                if (m_phase[u] >= 1 && m_phase[u] <= wid(u)) acc_cnt[u] <= acc_cnt[u] - 1;
                m_phase[u] <= 0;
                e_res[u]   <= '0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                if (m_phase[u] >= 1 && m_phase[u] < wid(u)) begin
                    m_phase[u] <= m_phase[u] + 1;
                end else if (m_phase[u] == wid(u)) begin
                    m_phase[u] <= wid(u) + 1;
                    e_res[u]   <= ref_res(wid(u), m_a[u], m_b[u], m_bin[u]);
                end else if (st[u]) begin
                    m_phase[u] <= 1;
                    m_a[u]     <= ai[u];
                    m_b[u]     <= bi[u];
                    m_bin[u]   <= bn[u];
                    acc_cnt[u] <= acc_cnt[u] + 1;
                end else begin
                    m_phase[u] <= 0;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("busy4", 32'(bu4), 32'(m_phase[0] >= 1 && m_phase[0] <= 4));
            chk("done4", 32'(dn4), 32'(m_phase[0] == 5));
            chk("diff4", 32'(d4),  e_res[0].diff);
            chk("bout4", 32'(bo4), 32'(e_res[0].bout));
            chk("ovf4",  32'(ov4), 32'(e_res[0].ovf));
            chk("zero4", 32'(z4),  32'(e_res[0].zero));
            chk("busy8", 32'(bu8), 32'(m_phase[1] >= 1 && m_phase[1] <= 8));
            chk("done8", 32'(dn8), 32'(m_phase[1] == 9));
            chk("diff8", 32'(d8),  e_res[1].diff);
            chk("bout8", 32'(bo8), 32'(e_res[1].bout));
            chk("ovf8",  32'(ov8), 32'(e_res[1].ovf));
            chk("zero8", 32'(z8),  32'(e_res[1].zero));
            if (dn4 === 1'b1) done_cnt[0]++;
            if (dn8 === 1'b1) done_cnt[1]++;
        end
    end

    // One 4-bit operation with literal expectations, latency and busy length.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                       input logic [3:0] ed, input logic eb, input logic eo, input logic ez,
                       input string tag);
        int cyc;
        int nb;
        @(negedge clk);
        ai[0] = 32'(a); bi[0] = 32'(b); bn[0] = bin; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        cyc = 1;
        nb  = 0;
        while (dn4 !== 1'b1 && cyc < 20) begin
            if (bu4 === 1'b1) nb++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'd5);
        chk({tag, "_busycycles"}, 32'(nb), 32'd4);
        chk({tag, "_diff"}, 32'(d4), 32'(ed));
        chk({tag, "_bout"}, 32'(bo4), 32'(eb));
        chk({tag, "_ovf"}, 32'(ov4), 32'(eo));
        chk({tag, "_zero"}, 32'(z4), 32'(ez));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        int   cyc;
        int   nd;
        int   tgt0;
        int   tgt1;

        for (int u = 0; u < 2; u++) begin
            st[u] = 1'b0; ai[u] = 32'd0; bi[u] = 32'd0; bn[u] = 1'b0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_diff", 32'(d4), 32'd0);
        chk("reset_flags", 32'({bo4, ov4, z4, bu4, dn4}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Pin the reference model with hand-computed values.
        r = ref_res(4, 32'h3, 32'h7, 1'b0);
        chk("ref_3m7_diff", r.diff, 32'hC);
        chk("ref_3m7_bout", 32'(r.bout), 32'd1);
        r = ref_res(8, 32'h80, 32'h01, 1'b0);
        chk("ref_80m01_diff", r.diff, 32'h7F);
        chk("ref_80m01_ovf", 32'(r.ovf), 32'd1);
        r = ref_res(8, 32'h00, 32'hFF, 1'b1);
        chk("ref_0mFF_b1", 32'({r.bout, r.zero, r.ovf}), 32'b110);

        // Directed 4-bit vectors.
        op4(4'd7, 4'd3, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, "7m3");
        op4(4'd3, 4'd7, 1'b0, 4'hC, 1'b1, 1'b0, 1'b0, "3m7");
        op4(4'd8, 4'd1, 1'b0, 4'h7, 1'b0, 1'b1, 1'b0, "8m1");
        op4(4'd7, 4'h8, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0, "7m8");
        op4(4'd5, 4'd5, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, "5m5");
        op4(4'd5, 4'd4, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, "5m4b");
        op4(4'd0, 4'd15, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, "0m15b");

        // start during computation is ignored; start in the strobe cycle is accepted.
        @(negedge clk);
        ai[0] = 32'd7; bi[0] = 32'd3; bn[0] = 1'b0; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        ai[0] = 32'd1; bi[0] = 32'd1; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        cyc = 3;
        while (dn4 !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("ignore_latency", 32'(cyc), 32'd5);
        chk("ignore_diff", 32'(d4), 32'h4);
        ai[0] = 32'd2; bi[0] = 32'd3; bn[0] = 1'b0; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        cyc = 1;
        while (dn4 !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_latency", 32'(cyc), 32'd5);
        chk("b2b_diff", 32'(d4), 32'hF);
        chk("b2b_bout", 32'(bo4), 32'd1);

        // Reset in the middle of an operation.
        @(negedge clk);
        ai[0] = 32'd7; bi[0] = 32'd3; bn[0] = 1'b0; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_diff", 32'(d4), 32'd0);
        chk("abort_flags", 32'({bo4, ov4, z4, bu4, dn4}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (dn4 === 1'b1) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        op4(4'd9, 4'd2, 1'b0, 4'h7, 1'b0, 1'b1, 1'b0, "9m2");

        // Random regression on both widths, including ignored and back-to-back starts.
        tgt0 = acc_cnt[0] + 1000;
        tgt1 = acc_cnt[1] + 1000;
        for (int c = 0; c < 40000; c++) begin
            if (acc_cnt[0] >= tgt0 && acc_cnt[1] >= tgt1) break;
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                st[u] = ($urandom_range(0, 3) != 0);
                ai[u] = $urandom;
                bi[u] = ($urandom_range(0, 7) == 0) ? ai[u] : $urandom;
                bn[u] = ($urandom_range(0, 1) != 0);
            end
        end
        st[0] = 1'b0;
        st[1] = 1'b0;
        repeat (12) @(negedge clk);
        chk("rand_count4", 32'(acc_cnt[0] >= tgt0), 32'd1);
        chk("rand_count8", 32'(acc_cnt[1] >= tgt1), 32'd1);
        chk("done_per_op4", 32'(done_cnt[0]), 32'(acc_cnt[0]));
        chk("done_per_op8", 32'(done_cnt[1]), 32'(acc_cnt[1]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit two's-complement subtractor: computes `a - b - bin` one bit per clock, LSB first. It uses a single full-subtractor cell and a registered borrow. It is the subtract counterpart to the lab's combinational ripple adder datapath, built for area-limited ALU paths where a few cycles of latency are acceptable. Operands are loaded on a start handshake. Results and flags are presented with a one-cycle `done` strobe and held until the next operation is accepted.

## Interface
- `WIDTH`, default 4: operand and result width in bits; legal range is 2 to 32.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset.
- One clock; reset is asynchronous and active-low.
- `start`  input  1  request; sampled only in state IDLE or DONE.
- `a`  input  WIDTH  minuend; sampled on the accepting edge.
- `b`  input  WIDTH  subtrahend; sampled on the accepting edge.
- `bin`  input  1  borrow-in; sampled on the accepting edge.
- `diff`  output  WIDTH  registered result, `a - b - bin` mod 2^WIDTH.
- `bout`  output  1  registered borrow-out; 1 when unsigned `a < b + bin`.
- `ovf`  output  1  registered signed overflow.
- `zero`  output  1  registered flag; 1 when `diff == 0`.
- `busy`  output  1  high while in state SHIFT.
- `done`  output  1  one-cycle strobe in state DONE.

## Operation
- States:
  - IDLE (reset state).
  - SHIFT.
  - DONE.
- IDLE:
  - If `start` is high, latch `a` into shift register `ra`, `b` into `rb`, and `bin` into borrow register `brw`.
  - Latch `a[WIDTH-1]` and `b[WIDTH-1]` into sign registers `sa` and `sb`.
  - Clear bit counter `cnt` and the internal result shift register `rd`, then go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, each cycle:
  - `d = ra[0] ^ rb[0] ^ brw`.
  - `brw <= (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & brw)`.
  - `rd <= {d, rd[WIDTH-1:1]}`.
  - Shift `ra` and `rb` right by 1.
  - `cnt <= cnt + 1`.
  - When `cnt == WIDTH-1`, go to DONE on this edge. On the same edge, load the output registers:
    - `diff <= {d, rd[WIDTH-1:1]}`.
    - `bout <=` the next borrow value.
    - `zero <= (({d, rd[WIDTH-1:1]}) == 0)`.
    - `ovf <= (sa != sb) && (d != sa)`.
- DONE:
  - `done = 1`.
  - If `start` is high, accept a new operation exactly as in IDLE and go to SHIFT (back-to-back operation).
  - Otherwise go to IDLE.
- `start` is ignored in SHIFT: no restart, and operands are not re-sampled.
- `diff`, `bout`, `ovf` and `zero` change only on the edge entering DONE. They hold their values through IDLE, SHIFT and later operations until the next completion.
- `cnt` width is `$clog2(WIDTH)` bits minimum. It never wraps inside an operation.
- `bin`:
  - `bin = 1` with `b = 2^WIDTH - 1` is legal.
  - The result is `a - 2^WIDTH` mod 2^WIDTH = `a`, with `bout = 1`.
  - `ovf` is computed from the final `d` and the sign registers only. `bin` does not enter the overflow rule separately.

## Timing
- Reset (`rst_n` low), at any time, including mid-SHIFT:
  - State goes to IDLE immediately and asynchronously.
  - `diff = 0`, `bout = 0`, `ovf = 0`, `zero = 0`, `busy = 0`, `done = 0`.
  - Internal registers are cleared; the in-flight operation is discarded.
- Release of `rst_n` is synchronized externally. The first possible accept is the first rising edge with `rst_n` high.
- Latency:
  - `start` accepted at edge E0.
  - `busy` is high during the WIDTH cycles after edges E0 through E(WIDTH-1).
  - Results are valid and `done` is high during the cycle after edge E(WIDTH).
  - Throughput is one operation per WIDTH+1 cycles with back-to-back `start`.
- `busy` and `done` are never high in the same cycle.
- `done` is high for exactly one cycle per accepted operation.

## Test plan
- 7 - 3, `bin = 0`, WIDTH = 4 → `diff = 4'h4`, `bout = 0`, `ovf = 0`, `zero = 0`. `done` is high exactly 5 cycles after the accepting edge; `busy` is high for 4 cycles.
- 3 - 7, `bin = 0` → `diff = 4'hC`, `bout = 1`, `ovf = 0`. Then 8 - 1 → `diff = 4'h7`, `bout = 0`, `ovf = 1`. Then 7 - 8 (i.e. 7 - 4'h8) → `diff = 4'hF`, `bout = 1`, `ovf = 1`.
- 5 - 5, `bin = 0` → `diff = 0`, `zero = 1`. Then 5 - 4, `bin = 1` → `diff = 0`, `zero = 1`, `bout = 0`. Then 0 - 15, `bin = 1` → `diff = 0`, `bout = 1`, `zero = 1`.
- Issue 7 - 3. Toggle `start` with 1 - 1 during SHIFT → ignored; result is 4. Assert `start` with 2 - 3 in the DONE cycle → accepted; next `done` after 5 cycles with `diff = 4'hF`, `bout = 1`.
- Drop `rst_n` two cycles into an operation → all outputs 0 immediately. After release, no `done` appears for the aborted operation. A new 9 - 2 gives `diff = 4'h7`.
- Random regression: 1000 operations each at WIDTH = 4 and WIDTH = 8. Compare against a reference model of `{bout, diff} = {1'b0, a} - b - bin` and the signed-overflow rule.
- Check every result for one `done` per accepted `start`, and that the outputs stay stable between completions.
